// File: rtl/ps2_letter_rx.sv
// PS/2 device-to-host receiver: synchronizes and filters kbdclk, frames bytes,
// and decodes scan-code set 2 make codes for A-Z into a held 5-bit letter.
module ps2_letter_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbdclk,
    input  logic       kbddat,
    output logic [4:0] letter,
    output logic       letter_valid,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic          kc_meta_q, kc_meta_d, kc_sync_q, kc_sync_d;
    logic          kd_meta_q, kd_meta_d, kd_sync_q, kd_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic          brk_q, brk_d, ext_q, ext_d;
    logic [4:0]    letter_q, letter_d;
    logic          letter_valid_q, letter_valid_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          code_valid_q, code_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          fall, timeout, good;
    logic [4:0]    lut;

    function automatic logic [4:0] letter_of(input logic [7:0] b);
        case (b)
            8'h1C: letter_of = 5'd1;  8'h32: letter_of = 5'd2;  8'h21: letter_of = 5'd3;
            8'h23: letter_of = 5'd4;  8'h24: letter_of = 5'd5;  8'h2B: letter_of = 5'd6;
            8'h34: letter_of = 5'd7;  8'h33: letter_of = 5'd8;  8'h43: letter_of = 5'd9;
            8'h3B: letter_of = 5'd10; 8'h42: letter_of = 5'd11; 8'h4B: letter_of = 5'd12;
            8'h3A: letter_of = 5'd13; 8'h31: letter_of = 5'd14; 8'h44: letter_of = 5'd15;
            8'h4D: letter_of = 5'd16; 8'h15: letter_of = 5'd17; 8'h2D: letter_of = 5'd18;
            8'h1B: letter_of = 5'd19; 8'h2C: letter_of = 5'd20; 8'h3C: letter_of = 5'd21;
            8'h2A: letter_of = 5'd22; 8'h1D: letter_of = 5'd23; 8'h22: letter_of = 5'd24;
            8'h35: letter_of = 5'd25; 8'h1A: letter_of = 5'd26;
            default: letter_of = 5'd0;
        endcase
    endfunction

    // Synchronizers and glitch filter; fall fires in the cycle the filter drops.
    always_comb begin
        kc_meta_d = kbdclk;
        kc_sync_d = kc_meta_q;
        kd_meta_d = kbddat;
        kd_sync_d = kd_meta_q;
        filt_d    = filt_q;
        fcnt_d    = '0;
        fall      = 1'b0;
        if (kc_sync_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = kc_sync_q;
                fall   = ~kc_sync_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        bcnt_d         = bcnt_q;
        sh_d           = sh_q;
        par_d          = par_q;
        brk_d          = brk_q;
        ext_d          = ext_q;
        letter_d       = letter_q;
        scan_code_d    = scan_code_q;
        letter_valid_d = 1'b0;
        code_valid_d   = 1'b0;
        frame_err_d    = 1'b0;
        good           = kd_sync_q & (^{sh_q, par_q});
        lut            = letter_of(sh_q);

        tmo_d   = (state_q == IDLE || fall) ? '0 : tmo_q + 1'b1;
        // A fall coinciding with expiry wins over the timeout.
        timeout = (state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

        if (timeout) begin
            state_d     = IDLE;
            bcnt_d      = '0;
            frame_err_d = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!kd_sync_q) begin
                        state_d = DATA;
                        bcnt_d  = '0;
                    end
                end
                DATA: begin
                    sh_d = {kd_sync_q, sh_q[7:1]};
                    if (bcnt_q == 3'd7) begin
                        state_d = PARITY;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    par_d   = kd_sync_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (good) begin
                        scan_code_d  = sh_q;
                        code_valid_d = 1'b1;
                        if (sh_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else if (sh_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (brk_q || ext_q) begin
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                        end else if (lut != 5'd0) begin
                            letter_d       = lut;
                            letter_valid_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            kc_meta_q      <= 1'b1;
            kc_sync_q      <= 1'b1;
            kd_meta_q      <= 1'b1;
            kd_sync_q      <= 1'b1;
            filt_q         <= 1'b1;
            fcnt_q         <= '0;
            tmo_q          <= '0;
            bcnt_q         <= '0;
            sh_q           <= '0;
            par_q          <= 1'b0;
            brk_q          <= 1'b0;
            ext_q          <= 1'b0;
            letter_q       <= '0;
            letter_valid_q <= 1'b0;
            scan_code_q    <= '0;
            code_valid_q   <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            kc_meta_q      <= kc_meta_d;
            kc_sync_q      <= kc_sync_d;
            kd_meta_q      <= kd_meta_d;
            kd_sync_q      <= kd_sync_d;
            filt_q         <= filt_d;
            fcnt_q         <= fcnt_d;
            tmo_q          <= tmo_d;
            bcnt_q         <= bcnt_d;
            sh_q           <= sh_d;
            par_q          <= par_d;
            brk_q          <= brk_d;
            ext_q          <= ext_d;
            letter_q       <= letter_d;
            letter_valid_q <= letter_valid_d;
            scan_code_q    <= scan_code_d;
            code_valid_q   <= code_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign letter       = letter_q;
    assign letter_valid = letter_valid_q;
    assign scan_code    = scan_code_q;
    assign code_valid   = code_valid_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_ps2_letter_rx.sv
// Directed and randomized PS/2 frames against a table-driven model of the
// scan-code decoder; pulse activity is counted per frame by a monitor.
module tb_ps2_letter_rx;

    localparam int unsigned TMO  = 2000;
    localparam int          HALF = 30;
    localparam int          GAP  = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbdclk = 1'b1;
    logic       kbddat = 1'b1;
    logic [4:0] letter;
    logic       letter_valid;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;

    ps2_letter_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .kbdclk(kbdclk), .kbddat(kbddat),
        .letter(letter), .letter_valid(letter_valid), .scan_code(scan_code),
        .code_valid(code_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cv_cyc = 0, lv_cyc = 0, fe_cyc = 0;
    always @(negedge clk) begin
        if (code_valid === 1'b1)   cv_cyc++;
        if (letter_valid === 1'b1) lv_cyc++;
        if (frame_err === 1'b1)    fe_cyc++;
    end

    int n_pass = 0, n_total = 0;

    byte unsigned letter_tab [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };

    // Reference model state
    int m_letter = 0, m_scan = 0;
    bit m_brk = 0, m_ext = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic send_bit(input logic v);
        @(posedge clk);
        kbddat = v;
        repeat (HALF) @(posedge clk);
        kbdclk = 1'b0;
        repeat (HALF) @(posedge clk);
        kbdclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i]);
        @(posedge clk);
        kbddat = 1'b1;
    endtask

    // Sends one frame, steps the model and compares pulses and held outputs.
    task automatic do_frame(input string name, input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int cv0, lv0, fe0, e_cv, e_lv, e_fe, idx;
        cv0 = cv_cyc; lv0 = lv_cyc; fe0 = fe_cyc;
        e_cv = 0; e_lv = 0; e_fe = 0;
        send_frame(b, bad_par, bad_stop);
        repeat (GAP) @(posedge clk);
        if (bad_par || bad_stop) begin
            e_fe = 1;
        end else begin
            e_cv = 1;
            m_scan = int'(b);
            if (b == 8'hF0) m_brk = 1;
            else if (b == 8'hE0) m_ext = 1;
            else if (m_brk || m_ext) begin
                m_brk = 0;
                m_ext = 0;
            end else begin
                idx = -1;
                for (int k = 0; k < 26; k++) if (letter_tab[k] == b) idx = k;
                if (idx >= 0) begin
                    m_letter = idx + 1;
                    e_lv = 1;
                end
            end
        end
        @(negedge clk);
        check($sformatf("%s/%02h code_valid", name, b), cv_cyc - cv0, e_cv);
        check($sformatf("%s/%02h letter_valid", name, b), lv_cyc - lv0, e_lv);
        check($sformatf("%s/%02h frame_err", name, b), fe_cyc - fe0, e_fe);
        check($sformatf("%s/%02h scan_code", name, b), {24'd0, scan_code}, m_scan);
        check($sformatf("%s/%02h letter", name, b), {27'd0, letter}, m_letter);
    endtask

    initial begin
        int cv0, fe0, kind;
        logic [7:0] rb;

        repeat (5) @(posedge clk);
        #1;
        check("reset letter", {27'd0, letter}, 0);
        check("reset scan_code", {24'd0, scan_code}, 0);
        check("reset pulses", {29'd0, letter_valid, code_valid, frame_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);

        do_frame("A", 8'h1C, 0, 0);
        do_frame("brk", 8'hF0, 0, 0);
        do_frame("A-rel", 8'h1C, 0, 0);
        do_frame("ext", 8'hE0, 0, 0);
        do_frame("ext-W", 8'h1D, 0, 0);
        do_frame("Z", 8'h1A, 0, 0);
        do_frame("typematic", 8'h1A, 0, 0);
        do_frame("badpar", 8'h32, 1, 0);
        do_frame("T", 8'h2C, 0, 0);
        do_frame("badstop", 8'h24, 0, 1);

        // Abandoned frame: start plus four data bits, then silence.
        cv0 = cv_cyc; fe0 = fe_cyc;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (TMO + 100) @(posedge clk);
        @(negedge clk);
        check("timeout frame_err", fe_cyc - fe0, 1);
        check("timeout code_valid", cv_cyc - cv0, 0);
        do_frame("Q", 8'h15, 0, 0);

        do_frame("key1", 8'h16, 0, 0);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midreset letter", {27'd0, letter}, 0);
        check("midreset scan_code", {24'd0, scan_code}, 0);
        m_letter = 0; m_scan = 0; m_brk = 0; m_ext = 0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        do_frame("postreset", 8'h4D, 0, 0);

        for (int n = 0; n < 36; n++) begin
            kind = $urandom_range(0, 9);
            rb = 8'($urandom_range(0, 255));
            case (kind)
                0, 1, 2, 3, 4: do_frame("rnd", letter_tab[$urandom_range(0, 25)], 0, 0);
                5:             do_frame("rnd", 8'hF0, 0, 0);
                6:             do_frame("rnd", 8'hE0, 0, 0);
                7:             do_frame("rnd", rb, 0, 0);
                8:             do_frame("rnd", rb, 1, 0);
                default:       do_frame("rnd", rb, 0, 1);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
